paralelo_serial_tx: RTL and testbench

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

---
 rtl/phy_pkg.sv | 13 +
 rtl/paralelo_serial_tx.sv | 89 ++++++++
 tb/tb_paralelo_serial_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY constants: byte width, default comma symbol and the TX lane state encoding.
package phy_pkg;

   localparam int unsigned       BYTE_W    = 8;
   localparam logic [BYTE_W-1:0] COMMA_DEF = 8'hBC;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// One TX lane: serialises bytes MSB first at the bit clock, sends an initial comma
// preamble after reset and fills idle byte slots with COMMA.
module paralelo_serial_tx
   import phy_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEF,
   parameter int unsigned       INIT_COMMAS = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              serial_out,
   output logic              active_out
);

   localparam logic [3:0] INIT_COMMAS_C = 4'(INIT_COMMAS);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] shreg_q, shreg_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        comma_cnt_q, comma_cnt_d;
   logic              active_q, active_d;
   logic              boundary;

   assign boundary   = (bit_cnt_q == 3'd7);
   assign ready_out  = (state_q == ST_ACTIVE) && boundary;
   assign serial_out = shreg_q[BYTE_W-1];
   assign active_out = active_q;

   always_comb begin
      state_d     = state_q;
      shreg_d     = {shreg_q[BYTE_W-2:0], 1'b0};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      comma_cnt_d = comma_cnt_q;
      case (state_q)
         ST_RESET: begin
            state_d     = ST_INIT;
            shreg_d     = COMMA;
            bit_cnt_d   = 3'd0;
            comma_cnt_d = 4'd0;
         end
         ST_INIT: begin
            if (boundary) begin
               // The byte loaded on the final preamble boundary is itself a comma.
               shreg_d     = COMMA;
               comma_cnt_d = comma_cnt_q + 4'd1;
               if (comma_cnt_q + 4'd1 == INIT_COMMAS_C) begin
                  state_d = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            if (boundary) begin
               if (valid_in) begin
                  shreg_d = data_in;
               end else begin
                  shreg_d = COMMA;
                  if (comma_cnt_q != 4'hF) begin
                     comma_cnt_d = comma_cnt_q + 4'd1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RESET;
         shreg_q     <= '0;
         bit_cnt_q   <= 3'd0;
         comma_cnt_q <= 4'd0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         active_q    <= active_d;
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: cycle-indexed reference model plus literal checks.
module tb_paralelo_serial_tx;

   localparam int         IC      = 4;
   localparam logic [7:0] COMMA_V = 8'hBC;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, serial_out, active_out;
   logic [7:0] data_in1 = 8'h00;
   logic       valid_in1 = 1'b0;
   logic       ready_out1, serial_out1, active_out1;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   int         m_n = 0;
   logic [7:0] m_byte = 8'h00;

   always #5 clk_32f = ~clk_32f;

   paralelo_serial_tx #(.COMMA(COMMA_V), .INIT_COMMAS(IC)) u_dut (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .serial_out(serial_out), .active_out(active_out));

   paralelo_serial_tx #(.COMMA(COMMA_V), .INIT_COMMAS(1)) u_dut1 (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in1), .valid_in(valid_in1),
      .ready_out(ready_out1), .serial_out(serial_out1), .active_out(active_out1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk_32f);
      #1;
   endtask

   // Model: m_n edges since release; byte k goes out on edges 8k+1..8k+8.
   // Bytes 0..IC are commas, later bytes are taken at the ready cycle.
   always @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         m_n    = 0;
         m_byte = 8'h00;
      end else begin
         if (m_n % 8 == 0) m_byte = (m_n > 8 * IC && valid_in) ? data_in : COMMA_V;
         m_n++;
      end
   end

   always @(negedge clk_32f) begin
      if (check_en) begin
         logic exp_ser, exp_act, exp_rdy;
         exp_ser = (m_n == 0) ? 1'b0 : m_byte[7 - ((m_n - 1) % 8)];
         exp_act = (m_n >= 8 * IC + 1);
         exp_rdy = (m_n >= 8 * IC + 8) && (m_n % 8 == 0);
         chk("model_serial", 32'(serial_out), 32'(exp_ser));
         chk("model_active", 32'(active_out), 32'(exp_act));
         chk("model_ready",  32'(ready_out),  32'(exp_rdy));
      end
   end

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      while (!ready_out && k < 20) begin
         tick();
         k++;
      end
      chk({name, "_ready_seen"}, 32'(ready_out), 32'd1);
   endtask

   initial begin
      logic [7:0]  b8;
      logic [23:0] b24;
      logic [31:0] b32;
      int          first_rdy;

      check_en = 1'b1;
      repeat (3) tick();
      chk("rst_serial", 32'(serial_out), 32'd0);
      chk("rst_active", 32'(active_out), 32'd0);
      chk("rst_ready",  32'(ready_out),  32'd0);

      // Idle preamble and first ready pulse
      reset = 1'b1;
      b8 = '0;
      for (int c = 1; c <= 64; c++) begin
         tick();
         if (c <= 8) b8 = {b8[6:0], serial_out};
         if (c == 8)  chk("init_first_byte", 32'(b8), 32'hBC);
         if (c == 32) chk("active_c32", 32'(active_out), 32'd0);
         if (c == 33) chk("active_c33", 32'(active_out), 32'd1);
         if (c == 39) chk("ready_c39", 32'(ready_out), 32'd0);
         if (c == 40) chk("ready_c40", 32'(ready_out), 32'd1);
         if (c == 8)  chk("ic1_active_c8", 32'(active_out1), 32'd0);
         if (c == 9)  chk("ic1_active_c9", 32'(active_out1), 32'd1);
         if (c == 15) chk("ic1_ready_c15", 32'(ready_out1), 32'd0);
         if (c == 16) chk("ic1_ready_c16", 32'(ready_out1), 32'd1);
      end

      // Back-to-back bytes with no comma between them
      wait_ready("b2b");
      b24 = '0;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         data_in  = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'hFF;
         for (int b = 0; b < 8; b++) begin
            tick();
            if (b == 0) valid_in = 1'b0;
            b24 = {b24[22:0], serial_out};
         end
      end
      chk("b2b_stream", 32'(b24), 32'hA53CFF);

      // Valid held only while ready is low must not be transmitted
      valid_in = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t < 7) begin
            valid_in = 1'b1;
            data_in  = 8'h55;
         end else begin
            valid_in = 1'b0;
         end
      end
      chk("ignored_ready_pulse", 32'(ready_out), 32'd1);
      b8 = '0;
      for (int b = 0; b < 8; b++) begin
         tick();
         b8 = {b8[6:0], serial_out};
      end
      chk("ignored_fill", 32'(b8), 32'hBC);

      // Randomised traffic, including valid toggling outside ready
      for (int t = 0; t < 800; t++) begin
         tick();
         valid_in = 1'($urandom_range(0, 1));
         data_in  = 8'($urandom);
      end
      valid_in = 1'b0;

      // Reset mid-byte, then full restart of the preamble
      wait_ready("mid");
      valid_in = 1'b1;
      data_in  = 8'hA5;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      chk("mid_bit_before_rst", 32'(serial_out), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_serial", 32'(serial_out), 32'd0);
      chk("mid_rst_active", 32'(active_out), 32'd0);
      chk("mid_rst_ready",  32'(ready_out),  32'd0);
      repeat (5) tick();
      chk("held_rst_serial", 32'(serial_out), 32'd0);
      reset = 1'b1;
      first_rdy = 0;
      b32 = '0;
      for (int c = 1; c <= 48; c++) begin
         tick();
         if (c <= 32) b32 = {b32[30:0], serial_out};
         if (ready_out && first_rdy == 0) first_rdy = c;
      end
      chk("restart_commas", b32, 32'hBCBCBCBC);
      chk("restart_first_ready", 32'(first_rdy), 32'd40);

      repeat (20) begin
         tick();
         valid_in = 1'($urandom_range(0, 1));
         data_in  = 8'($urandom);
      end
      tick();
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
